// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: holds operands on the shared multiplier, runs a
// 32-step restoring divider, re-signs results and owns the HI/LO registers.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = (MUL_CYCLES > 32) ? $clog2(MUL_CYCLES) : 5;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // rem:quo is the divider shift pair; in MUL quo holds |a|, later both hold the product.
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dvs_q, dvs_d;
  logic             is_mul_q, is_mul_d;
  logic             neg_q, neg_d;
  logic             rsign_q, rsign_d;
  logic             div0_q, div0_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;

  logic        signed_op;
  logic        accept;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted;
  logic [63:0] prod_fix;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign accept    = start && !cancel && (state_q == S_IDLE);
  assign abs_a     = (signed_op && a[31]) ? -a : a;
  assign abs_b     = (signed_op && b[31]) ? -b : b;
  assign shifted   = {rem_q, quo_q[31]};
  assign prod_fix  = neg_q ? -{rem_q, quo_q} : {rem_q, quo_q};

  // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    is_mul_d = is_mul_q;
    neg_d    = neg_q;
    rsign_d  = rsign_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_mul_d = (op == OP_MULT) || (op == OP_MULTU);
              state_d  = is_mul_d ? S_MUL : S_DIV;
              cnt_d    = is_mul_d ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(31);
              rem_d    = '0;
              quo_d    = abs_a;
              dvs_d    = abs_b;
              neg_d    = signed_op && (a[31] ^ b[31]);
              rsign_d  = signed_op && a[31];
              div0_d   = (b == '0);
            end
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {rem_d, quo_d} = mul_p;
          state_d        = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          quo_d = {quo_q[30:0], 1'b0};
          if (shifted >= {1'b0, dvs_q}) begin
            rem_d    = 32'(shifted - {1'b0, dvs_q});
            quo_d[0] = 1'b1;
          end else begin
            rem_d = shifted[31:0];
          end
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_mul_q) begin
            {hi_d, lo_d} = prod_fix;
          end else begin
            // With a zero divisor the remainder path already holds |a|, so re-signing gives raw a.
            hi_d = rsign_q ? -rem_q : rem_q;
            lo_d = div0_q ? '1 : (neg_q ? -quo_q : quo_q);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      rsign_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      is_mul_q <= is_mul_d;
      neg_q    <= neg_d;
      rsign_q  <= rsign_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign mul_a = (state_q == S_MUL) ? quo_q : '0;
  assign mul_b = (state_q == S_MUL) ? dvs_q : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: table of MULT/DIV vectors through a scoreboard
// queue, plus hand-written sequences for MTHI/MTLO, cancel, ignored starts and reset.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Environment model of the shared combinational multiplier.
  assign mul_p = {32'b0, mul_a} * {32'b0, mul_b};

  muldiv_ctrl #(.MUL_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_p  (mul_p),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op, then watch busy/done until the result appears (bounded).
  task automatic run_vec(input vec_t v);
    int   cyc;
    int   busy_cnt;
    bit   got;
    vec_t e;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_cnt = 0; got = 0;
    while (!got && cyc <= 100) begin
      if (done) got = 1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
        cyc++;
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      check($sformatf("%s_done_timeout", e.name), 64'(got), 64'd1);
    end else begin
      check($sformatf("%s_hi", e.name), 64'(hi), 64'(e.exp_hi));
      check($sformatf("%s_lo", e.name), 64'(lo), 64'(e.exp_lo));
      check($sformatf("%s_latency", e.name), 64'(cyc), 64'(e.lat));
      check($sformatf("%s_busy_cycles", e.name), 64'(busy_cnt), 64'(e.lat - 1));
      check($sformatf("%s_busy_at_done", e.name), 64'(busy), 64'd0);
      @(negedge clk);
      check($sformatf("%s_done_pulse", e.name), 64'(done), 64'd0);
    end
  endtask

  // Advance n cycles, counting done and busy samples seen.
  task automatic quiet_window(input int n, output int dones, output int busies);
    dones = 0; busies = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn, bz;
    vecs.push_back('{"multu_max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 6});
    vecs.push_back('{"mult_m3x7",  3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 6});
    vecs.push_back('{"mult_minsq", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 6});
    vecs.push_back('{"multu_shift",3'b001, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 6});
    vecs.push_back('{"div_m7_2",   3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34});
    vecs.push_back('{"div_7_m2",   3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34});
    vecs.push_back('{"divu_100_7", 3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       34});
    vecs.push_back('{"div_ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34});
    vecs.push_back('{"divu_by0",   3'b011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 34});
    vecs.push_back('{"div_m5_by0", 3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 34});
    vecs.push_back('{"divu_max_1", 3'b011, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 34});
    vecs.push_back('{"divu_big",   3'b011, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1,        34});

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
    #12;
    check("reset_outputs", {busy, done, hi, mul_a[0], mul_b[0]}, '0);
    check("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // MTHI then MTLO back-to-back: two done pulses, busy never asserted.
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(negedge clk);
    check("mthi_done", 64'(done), 64'd1);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_busy", 64'(busy), 64'd0);
    op = 3'b101; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_done", 64'(done), 64'd1);
    check("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
    check("mtlo_hi_kept", 64'(hi), 64'h12345678);
    check("mtlo_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("mt_done_end", 64'(done), 64'd0);

    // Cancel and start in the same idle cycle: the op is dropped.
    start = 1'b1; cancel = 1'b1; op = 3'b100; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_done", 64'(done), 64'd0);
    check("cancel_start_hi", 64'(hi), 64'h12345678);

    // Reserved op codes are ignored.
    start = 1'b1; op = 3'b110; a = 32'h1; b = 32'h1;
    @(negedge clk);
    op = 3'b111;
    @(negedge clk);
    start = 1'b0;
    quiet_window(3, dn, bz);
    check("bad_op_done", 64'(dn), 64'd0);
    check("bad_op_busy", 64'(bz), 64'd0);
    check("bad_op_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});

    // start while busy is ignored; the running MULTU finishes on time.
    start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("hold_mul_a", 64'(mul_a), 64'd3);
    check("hold_mul_b", 64'(mul_b), 64'd5);
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_hold_a", 64'(mul_a), 64'd3);
    @(negedge clk);
    @(negedge clk);
    check("busy_start_fix_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_start_done", 64'(done), 64'd1);
    check("busy_start_result", {hi, lo}, {32'd0, 32'd15});
    quiet_window(40, dn, bz);
    check("busy_start_no_extra_done", 64'(dn), 64'd0);
    check("busy_start_no_extra_busy", 64'(bz), 64'd0);

    // DIV cancelled in cycle 10: idle in cycle 11, hi/lo unchanged, no done.
    start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    check("cancel_div_busy_c10", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_div_idle_c11", 64'(busy), 64'd0);
    quiet_window(40, dn, bz);
    check("cancel_div_no_done", 64'(dn), 64'd0);
    check("cancel_div_no_busy", 64'(bz), 64'd0);
    check("cancel_div_hilo", {hi, lo}, {32'd0, 32'd15});

    // Asynchronous reset in cycle 3 of a MULT.
    start = 1'b1; op = 3'b000; a = 32'hFFFFFFFD; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_mul_a", 64'(mul_a), 64'd3);
    check("rst_mid_mul_b", 64'(mul_b), 64'd7);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {busy, done, mul_a, mul_b}, '0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window(10, dn, bz);
    check("rst_mid_no_done", 64'(dn), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
